// File: rtl/per_bus_master.sv
// rtl/per_bus_master.sv - byte-stream command decoder driving single peripheral bus transactions
// Ports:
//   clk_i, reset_i            clock, asynchronous active-low reset
//   rx_data_i/valid/ready     command byte stream in (valid/ready handshake)
//   tx_data_o/valid/ready     response byte stream out (valid/ready handshake)
//   addr_o, wdata_o, size_o   bus address, write data, access size (held between strobes)
//   rdata_i                   bus read data, valid READ_LATENCY cycles after rd_o
//   rd_o, wr_o                single-cycle bus read/write strobes
//   busy_o                    a command or response is in progress
module per_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [15:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic [1:0]  size_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic        busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    size_stage_q, size_stage_d;
  logic [15:0]   addr_stage_q, addr_stage_d;
  logic [23:0]   wbuf_q, wbuf_d;
  logic [1:0]    data_cnt_q, data_cnt_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [23:0]   resp_q, resp_d;
  logic [2:0]    resp_cnt_q, resp_cnt_d;

  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;

  logic accept;
  logic cmd_rd;
  logic cmd_wr;
  logic tmo_hit;

  // rx_ready_q tracks the current state, so it is the live ready of this cycle.
  assign accept  = rx_valid_i & rx_ready_q;
  assign cmd_rd  = (rx_data_i[7:2] == 6'b000100) && (rx_data_i[1:0] != 2'b11);
  assign cmd_wr  = (rx_data_i[7:2] == 6'b001000) && (rx_data_i[1:0] != 2'b11);
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    size_stage_d = size_stage_q;
    addr_stage_d = addr_stage_q;
    wbuf_d       = wbuf_q;
    data_cnt_d   = data_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    resp_d       = resp_q;
    resp_cnt_d   = resp_cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (accept) begin
          if (cmd_rd || cmd_wr) begin
            is_wr_d      = cmd_wr;
            size_stage_d = rx_data_i[1:0];
            state_d      = S_ADDR_HI;
          end else begin
            // Unknown opcode: only an error byte; following bytes are decoded afresh.
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'hEE;
            resp_cnt_d = 3'd1;
          end
        end
      end

      S_ADDR_HI: begin
        if (accept) begin
          addr_stage_d[15:8] = rx_data_i;
          tmo_cnt_d          = '0;
          state_d            = S_ADDR_LO;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      S_ADDR_LO: begin
        if (accept) begin
          addr_stage_d = {addr_stage_q[15:8], rx_data_i};
          tmo_cnt_d    = '0;
          if (is_wr_q) begin
            data_cnt_d = 2'd0;
            state_d    = S_DATA;
          end else begin
            rd_d    = 1'b1;
            addr_d  = {addr_stage_q[15:8], rx_data_i};
            size_d  = size_stage_q;
            state_d = S_BUS_RD;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      S_DATA: begin
        if (accept) begin
          tmo_cnt_d = '0;
          if (data_cnt_q == 2'd3) begin
            wr_d    = 1'b1;
            wdata_d = {wbuf_q, rx_data_i};
            addr_d  = addr_stage_q;
            size_d  = size_stage_q;
            state_d = S_BUS_WR;
          end else begin
            wbuf_d     = {wbuf_q[15:0], rx_data_i};
            data_cnt_d = data_cnt_q + 2'd1;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      S_BUS_WR: begin
        state_d    = S_RESP;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'hA5;
        resp_cnt_d = 3'd1;
      end

      S_BUS_RD: begin
        lat_cnt_d = 3'd1;
        state_d   = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // lat_cnt_q counts cycles since the rd_o cycle; capture when it equals the latency.
        if (lat_cnt_q == 3'(READ_LATENCY)) begin
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = rdata_i[31:24];
          resp_d     = rdata_i[23:0];
          resp_cnt_d = 3'd4;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end

      S_RESP: begin
        if (tx_ready_i) begin
          if (resp_cnt_q == 3'd1) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d  = resp_q[23:16];
            resp_d     = {resp_q[15:0], 8'h00};
            resp_cnt_d = resp_cnt_q - 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR_HI) ||
                 (state_d == S_ADDR_LO) || (state_d == S_DATA);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      is_wr_q      <= 1'b0;
      size_stage_q <= '0;
      addr_stage_q <= '0;
      wbuf_q       <= '0;
      data_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      resp_q       <= '0;
      resp_cnt_q   <= '0;
      rx_ready_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      size_stage_q <= size_stage_d;
      addr_stage_q <= addr_stage_d;
      wbuf_q       <= wbuf_d;
      data_cnt_q   <= data_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      resp_q       <= resp_d;
      resp_cnt_q   <= resp_cnt_d;
      rx_ready_q   <= rx_ready_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign size_o     = size_q;
  assign rd_o       = rd_q;
  assign wr_o       = wr_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/per_bus_master.md
# per_bus_master

Byte-stream-to-peripheral-bus initiator. Sits between a byte source/sink (typically the debug UART's RX/TX byte channels) and the peripheral bus, which it drives as initiator. Decodes framed read/write commands and issues single bus transactions on the same bus GPIO and other peripherals respond to. Returns read data or a write acknowledge as response bytes.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed between bytes of one command before the command is abandoned.
- `READ_LATENCY`, default 1: cycles from the `rd_o` cycle to valid `rdata_i`; range 1..4.
- `clk_i` input 1: the single clock.
- `reset_i` input 1: asynchronous, active-low reset.
- `rx_data_i` input 8: command byte.
- `rx_valid_i` input 1: `rx_data_i` valid.
- `rx_ready_o` output 1: block accepts a byte; transfer occurs when `rx_valid_i` and `rx_ready_o` are both high.
- `tx_data_o` output 8: response byte.
- `tx_valid_o` output 1: `tx_data_o` valid.
- `tx_ready_i` input 1: sink accepts the byte.
- `addr_o` output 16: bus address.
- `wdata_o` output 32: bus write data.
- `rdata_i` input 32: bus read data.
- `size_o` output 2: access size (0 byte, 1 half, 2 word).
- `rd_o` output 1: bus read strobe.
- `wr_o` output 1: bus write strobe.
- `busy_o` output 1: a command is in progress (any state other than IDLE).

## Operation
- Command framing:
  - Byte 0 is the command: 0x10|size = read, 0x20|size = write, with size in bits [1:0].
  - Bytes 1 and 2 are the address, high byte then low byte.
  - A write adds 4 data bytes, MSB first.
- Any other command byte, or size = 3:
  - Enter RESP with the single byte 0xEE.
  - No bus access is made.
  - The address and data bytes that follow are not skipped: each is decoded as a new command byte.
- FSM states: IDLE → ADDR_HI → ADDR_LO → (write: DATA ×4 → BUS_WR) / (read: BUS_RD → RD_WAIT) → RESP → IDLE.
- `rx_ready_o` = 1 only in IDLE, ADDR_HI, ADDR_LO and DATA.
- BUS_WR:
  - `wr_o` = 1 for exactly one cycle.
  - `addr_o`, `wdata_o` and `size_o` are stable that cycle.
  - Then RESP with the byte 0xA5.
- BUS_RD:
  - `rd_o` = 1 for exactly one cycle, with `addr_o` and `size_o` stable.
  - RD_WAIT counts so that `rdata_i` is captured exactly `READ_LATENCY` cycles after the `rd_o` cycle.
  - Then RESP with 4 bytes, MSB first.
- RESP:
  - Holds `tx_valid_o` = 1 and a stable `tx_data_o` until `tx_ready_i`.
  - The next byte is presented on the following cycle; after the last byte is accepted, go to IDLE.
  - No timeout applies in RESP.
- Timeout:
  - A counter runs in ADDR_HI, ADDR_LO and DATA and clears on each accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, go to IDLE: no bus access, no response, partial fields discarded.
- Byte-lane placement and alignment checks are the responder's job. `wdata_o` is passed through as received.
- `addr_o`, `wdata_o` and `size_o` hold their last values outside strobe cycles.

## Timing
- Reset:
  - All outputs are 0 and the state is IDLE.
  - `rx_ready_o` rises on the first clock edge after `reset_i` deasserts.
  - Reset asserted mid-command or mid-response aborts immediately: strobes and `tx_valid_o` drop asynchronously.
- All outputs are registered; there is no combinational path from an input to an output.
- Write latency: `wr_o` is asserted on the cycle after the last data byte is accepted. The first response byte (0xA5) is valid the cycle after `wr_o`.
- Read latency: `rd_o` is asserted on the cycle after the ADDR_LO byte is accepted. The first response byte is valid the cycle after `rdata_i` is captured (`READ_LATENCY`+1 cycles after `rd_o`).
- A byte offered while `rx_ready_o` = 0 is not consumed; the source must hold it.
- `rd_o` and `wr_o` are never high in the same cycle, and each is at most 1 cycle per command.
- `tx_valid_o` never drops without a handshake, except on reset.

## Test plan
- Write: bytes 0x22,0x00,0x04,0xDE,0xAD,0xBE,0xEF →
  - exactly one `wr_o` pulse with `addr_o`=0x0004, `wdata_o`=0xDEADBEEF, `size_o`=2;
  - then the single tx byte 0xA5.
- Read, `READ_LATENCY`=1, responder returns 0x12345678: bytes 0x12,0x00,0x10 →
  - one `rd_o` pulse with `addr_o`=0x0010;
  - tx bytes 0x12,0x34,0x56,0x78 in order.
- Backpressure: `tx_ready_i` low for 5 cycles on each response byte → each byte held stable, none lost or duplicated; `rx_ready_o` stays 0 until all 4 bytes are sent.
- Bad command: byte 0x33, then 0x7F →
  - tx 0xEE twice;
  - no `rd_o` or `wr_o`.
- Timeout with `TIMEOUT_CYCLES`=16: bytes 0x22,0x00, then a gap of 16 cycles, then a full read command →
  - first command dropped with no bus access;
  - read completes normally.
- Async reset asserted in DATA after 2 data bytes → all outputs 0 immediately; after release a full write completes correctly.
